// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared encodings, entry width and byte-count helper for the
//                instruction-cache fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int ENTRY_W = 36;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_READ  = 2'd1;
    localparam state_t c_ST_DRAIN = 2'd2;

    // Useful bytes in a beat: bounded by what the dword offers and what is left.
    function automatic logic [2:0] min_len(input logic [2:0] avail, input logic [31:0] rem);
        if (rem < 32'(avail)) begin
            return rem[2:0];
        end
        return avail;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : icache_skid_fifo
//  Description : Show-ahead synchronous FIFO holding trimmed cache beats;
//                flush wins over a simultaneous push.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_skid_fifo
    import icache_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : icache_fetch_seq
//  Description : Issues one L1 line read per fetch request, trims and aligns
//                returned dwords, and drains them into the prefetch FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_fetch_seq
    import icache_pkg::*;
#(
    parameter int BEATS = 4,
    parameter int LEN_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pr_reset,
    input  logic               icacheread_do,
    input  logic [31:0]        icacheread_address,
    input  logic [LEN_W-1:0]   icacheread_length,
    output logic               cache_req,
    output logic [31:0]        cache_addr,
    input  logic               cache_valid,
    input  logic [31:0]        cache_data,
    input  logic               cache_done,
    input  logic               prefetchfifo_ready,
    output logic               prefetchfifo_write_do,
    output logic [ENTRY_W-1:0] prefetchfifo_write_data,
    output logic               prefetched_do,
    output logic [4:0]         prefetched_length,
    output logic               busy
);

    localparam int c_BEAT_W = $clog2(BEATS) + 1;

    state_t              r_state;
    logic [1:0]          r_off;
    logic [LEN_W-1:0]    r_rem;
    logic [c_BEAT_W-1:0] r_beat;

    state_t              w_state_nxt;
    logic                w_req;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_full;
    logic [2:0]          w_avail;
    logic [2:0]          w_n;
    logic [1:0]          w_shamt;
    logic [31:0]         w_shift;
    logic [31:0]         w_trim;
    logic [ENTRY_W-1:0]  w_entry;
    logic [ENTRY_W-1:0]  w_head;

    // ------------------------------------------------------------------
    // Next-state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_req = icacheread_do && (icacheread_length != '0) && !pr_reset && w_empty;
                if (w_req) begin
                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_READ: begin
                if (pr_reset) begin
                    w_state_nxt = cache_done ? c_ST_IDLE : c_ST_DRAIN;
                end else begin
                    w_push = cache_valid && (r_rem != '0);
                    if (cache_done) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_DRAIN: begin
                if (cache_done) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_off   <= '0;
            r_rem   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req) begin
                r_off  <= icacheread_address[1:0];
                r_rem  <= icacheread_length;
                r_beat <= '0;
            end else if ((r_state == c_ST_READ) && cache_valid && !pr_reset) begin
                r_rem  <= r_rem - LEN_W'(w_n);
                r_beat <= r_beat + c_BEAT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Trim/align datapath: only the first beat is offset by the fetch address
    // ------------------------------------------------------------------
    assign w_avail = (r_beat == '0) ? (3'd4 - {1'b0, r_off}) : 3'd4;
    assign w_n     = min_len(w_avail, 32'(r_rem));
    assign w_shamt = (r_beat == '0) ? r_off : 2'b00;
    assign w_shift = cache_data >> {w_shamt, 3'b000};

    for (genvar k = 0; k < 4; k++) begin : g_trim
        assign w_trim[8*k +: 8] = (w_n > 3'(k)) ? w_shift[8*k +: 8] : 8'h00;
    end

    assign w_entry = {1'b0, w_n, w_trim};

    icache_skid_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BEATS)
    ) u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (pr_reset),
        .i_data  (w_entry),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // ------------------------------------------------------------------
    // Output handshake
    // ------------------------------------------------------------------
    assign w_pop                   = !w_empty && prefetchfifo_ready && !pr_reset;
    assign cache_req               = w_req;
    assign cache_addr              = {icacheread_address[31:2], 2'b00};
    assign prefetchfifo_write_do   = w_pop;
    assign prefetched_do           = w_pop;
    assign prefetchfifo_write_data = w_pop ? w_head : '0;
    assign prefetched_length       = w_pop ? {1'b0, w_head[35:32]} : 5'd0;
    assign busy                    = (r_state != c_ST_IDLE) || !w_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_push && w_full && !w_pop));
            assert (!(cache_valid && (r_state == c_ST_IDLE)));
        end
    end

endmodule
`default_nettype wire
